// File: rtl/cont_cres_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cont_cres_bcd: two-digit BCD up counter, programmable modulus,     |
// | preset load, sticky target-reached flag and cascadable terminal.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cont_cres_bcd #(
  parameter int MOD = 60
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic       Load,
  input  logic [3:0] LdT,
  input  logic [3:0] LdU,
  input  logic [3:0] TgtT,
  input  logic [3:0] TgtU,
  output logic [3:0] QT,
  output logic [3:0] QU,
  output logic       Tc,
  output logic       Done
);

  localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_U = 4'((MOD - 1) % 10);
  localparam logic [7:0] MOD_V = 8'(MOD);

  // A value is usable only if both digits are BCD and it lies inside the count range.
  function automatic logic bcd_in_range(input logic [3:0] t, input logic [3:0] u);
    logic [7:0] val;
    val = ({4'd0, t} * 8'd10) + {4'd0, u};
    bcd_in_range = (t <= 4'd9) && (u <= 4'd9) && (val < MOD_V);
  endfunction

  logic       at_max;
  logic       ld_ok;
  logic       tgt_ok;
  logic [3:0] nxt_t;
  logic [3:0] nxt_u;
  logic       hit;

  assign at_max = (QT == MAX_T) && (QU == MAX_U);
  assign ld_ok  = bcd_in_range(LdT, LdU);
  assign tgt_ok = bcd_in_range(TgtT, TgtU);
  assign Tc     = En & at_max;

  always_comb begin
    nxt_t = QT;
    nxt_u = QU;
    if (at_max) begin
      nxt_t = 4'd0;
      nxt_u = 4'd0;
    end else if (QU == 4'd9) begin
      nxt_t = QT + 4'd1;
      nxt_u = 4'd0;
    end else begin
      nxt_u = QU + 4'd1;
    end
  end

  assign hit = tgt_ok && (nxt_t == TgtT) && (nxt_u == TgtU);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      QT   <= 4'd0;
      QU   <= 4'd0;
      Done <= 1'b0;
    end else if (Load) begin
      QT   <= ld_ok ? LdT : 4'd0;
      QU   <= ld_ok ? LdU : 4'd0;
      Done <= 1'b0;
    end else if (En) begin
      QT <= nxt_t;
      QU <= nxt_u;
      // Only an increment can set the flag; it is sticky until Rst or Load.
      if (hit) begin
        Done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
